// File: rtl/updn_counter_pkg.sv
// Purpose: shared direction encodings and the next-count helper for updn_mod_counter.
// Latency: n/a (package of constants and a pure function).
// Backpressure: n/a.
// Ports: none.
package updn_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Internal arithmetic width: one bit wider than the widest legal counter
  // (16 bits), so MOD = 2^16 and MOD-1 are both representable.
  localparam int CNT_W = 17;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Next value for a counted edge. The result is CNT_W bits wide and the
  // caller truncates it to its own WIDTH. The result is always below mod,
  // so the truncation is lossless.
  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] q,
    input logic             x,
    input logic [CNT_W-1:0] mod,
    input logic             sat
  );
    logic [CNT_W-1:0] nxt;
    nxt = q;
    if (x == DIR_UP) begin
      if (q == mod - ONE) nxt = sat ? q : '0;
      else                nxt = q + ONE;
    end else begin
      if (q == '0)        nxt = sat ? q : mod - ONE;
      else                nxt = q - ONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/updn_negedge_reg.sv
// Purpose: WIDTH-bit falling-edge register with asynchronous active-high clear.
// Latency: d appears on q one falling edge after it is sampled.
// Backpressure: none; captures every falling edge.
// Ports: clk, reset (async, active-high), d [WIDTH-1:0] in, q [WIDTH-1:0] out.
module updn_negedge_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) val_q <= '0;
    else       val_q <= d;
  end

  assign q = val_q;

endmodule

// File: rtl/updn_mod_counter.sv
// Purpose: modulo-MOD up/down counter with load, enable, Mealy tc and sticky wrap flag.
// Latency: q/wrap update one falling edge after sampling; tc is combinational (zero latency).
// Backpressure: none; every falling edge is either a load, a count or a hold.
// Ports: clk, reset (async, active-high), x (1=up), en, load, d [WIDTH-1:0], clr_wrap,
//        q [WIDTH-1:0], tc, wrap.
// Config: define UPDN_COUNTER_SAT_EN to make the count saturate at the bounds instead of wrapping.
module updn_mod_counter
  import updn_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] MOD_W  = CNT_W'(MOD);
  localparam logic [CNT_W-1:0] MOD_M1 = CNT_W'(MOD - 1);

`ifdef UPDN_COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] q_ext, d_ext, load_ext;
  logic             tc_c;

  always_comb begin
    q_ext = CNT_W'(q_q);
    d_ext = CNT_W'(d);

    // Out-of-range load values clamp to the top of the count range.
    load_ext = (d_ext < MOD_W) ? d_ext : MOD_M1;

    tc_c = en & (((x == DIR_UP)   & (q_ext == MOD_M1)) |
                 ((x == DIR_DOWN) & (q_ext == '0)));

    q_d = q_q;
    if (load)    q_d = WIDTH'(load_ext);
    else if (en) q_d = WIDTH'(next_count(q_ext, x, MOD_W, SAT));

    // A set on the same edge as clr_wrap wins. A load edge never sets the flag.
    wrap_d = (tc_c & ~load) | (wrap_q & ~clr_wrap);
  end

  updn_negedge_reg #(.WIDTH(WIDTH)) u_q_reg (
    .clk   (clk),
    .reset (reset),
    .d     (q_d),
    .q     (q_q)
  );

  updn_negedge_reg #(.WIDTH(1)) u_wrap_reg (
    .clk   (clk),
    .reset (reset),
    .d     (wrap_d),
    .q     (wrap_q)
  );

  assign q    = q_q;
  assign tc   = tc_c;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Purpose: self-checking bench for updn_mod_counter (instances MOD=10/WIDTH=4 and MOD=4/WIDTH=2).
// Latency: checks q/wrap 1 time unit after each falling edge, tc just after inputs change.
// Backpressure: n/a.
module tb_updn_mod_counter;

`ifdef UPDN_COUNTER_SAT_EN
  localparam bit SAT_MODE = 1'b1;
  int exp_dn[3] = '{0, 0, 0};
  int exp_up[6] = '{1, 2, 3, 3, 3, 3};
`else
  localparam bit SAT_MODE = 1'b0;
  int exp_dn[3] = '{9, 8, 7};
  int exp_up[6] = '{1, 2, 3, 0, 1, 2};
`endif

  logic       clk = 1'b0;
  logic       reset, x, en, load, clr_wrap;
  logic [3:0] d_a, q_a;
  logic [1:0] d_b, q_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 is the MOD=10 instance, index 1 the MOD=4 instance.
  int m_q[2]    = '{0, 0};
  bit m_wrap[2] = '{1'b0, 1'b0};
  int m_mod[2]  = '{10, 4};

  always #5 clk = ~clk;

  updn_mod_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
    .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .d(d_a),
    .clr_wrap(clr_wrap), .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  updn_mod_counter #(.WIDTH(2), .MOD(4)) u_dut_b (
    .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .d(d_b),
    .clr_wrap(clr_wrap), .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_tc(input int k);
    if (!en) return 1'b0;
    if (x)   return m_q[k] == m_mod[k] - 1;
    return m_q[k] == 0;
  endfunction

  task automatic model_edge();
    int dv;
    bit t;
    for (int k = 0; k < 2; k++) begin
      t  = model_tc(k);
      dv = (k == 0) ? int'(d_a) : int'(d_b);
      if (reset) begin
        m_q[k]    = 0;
        m_wrap[k] = 1'b0;
      end else begin
        if (load) begin
          m_q[k] = (dv < m_mod[k]) ? dv : m_mod[k] - 1;
        end else if (en) begin
          if (x) begin
            if (!(SAT_MODE && m_q[k] == m_mod[k] - 1)) m_q[k] = (m_q[k] + 1) % m_mod[k];
          end else begin
            if (!(SAT_MODE && m_q[k] == 0)) m_q[k] = (m_q[k] + m_mod[k] - 1) % m_mod[k];
          end
        end
        if (t && !load)    m_wrap[k] = 1'b1;
        else if (clr_wrap) m_wrap[k] = 1'b0;
      end
    end
  endtask

  // Inputs must already be set (away from the falling edge) when called.
  task automatic cycle();
    #1;
    check_val("tc_a", tc_a, model_tc(0));
    check_val("tc_b", tc_b, model_tc(1));
    @(negedge clk);
    model_edge();
    #1;
    check_val("q_a", q_a, m_q[0]);
    check_val("q_b", q_b, m_q[1]);
    check_val("wrap_a", wrap_a, m_wrap[0]);
    check_val("wrap_b", wrap_b, m_wrap[1]);
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    check_val("arst_q_a", q_a, 0);
    check_val("arst_wrap_a", wrap_a, 0);
    check_val("arst_q_b", q_b, 0);
    check_val("arst_wrap_b", wrap_b, 0);
    m_q    = '{0, 0};
    m_wrap = '{1'b0, 1'b0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; x = 1'b0; en = 1'b1; load = 1'b0; clr_wrap = 1'b0;
    d_a = '0; d_b = '0;

    // Reset state; tc = en & ~x while q is held at 0.
    #12;
    check_val("rst_q_a", q_a, 0);
    check_val("rst_wrap_a", wrap_a, 0);
    check_val("rst_tc_a_dn", tc_a, 1);
    check_val("rst_tc_b_dn", tc_b, 1);
    x = 1'b1;
    #1;
    check_val("rst_tc_a_up", tc_a, 0);
    x = 1'b0;
    @(negedge clk);
    #1;
    check_val("rst_hold_q_a", q_a, 0);
    reset = 1'b0;

    // Count down from 0 on MOD=10: tc immediately, then wraps to 9.
    #1;
    check_val("dn_tc_start", tc_a, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("dn_seq_a", q_a, exp_dn[i]);
    end

    // Load clamp, then load beating an enabled count.
    load = 1'b1; en = 1'b0; d_a = 4'd13; d_b = 2'd1;
    cycle();
    check_val("load_clamp", q_a, 9);
    check_val("load_no_wrap_a", wrap_a, m_wrap[0]);
    en = 1'b1; x = 1'b1; d_a = 4'd5;
    cycle();
    check_val("load_wins", q_a, 5);
    d_a = 4'd7;
    cycle();
    check_val("load_7", q_a, 7);
    load = 1'b0; en = 1'b0;

    // Reset between edges clears immediately; a load during reset is dropped.
    async_reset_check();
    load = 1'b1; d_a = 4'd5; d_b = 2'd2;
    cycle();
    check_val("rst_load_drop", q_a, 0);
    load = 1'b0;
    reset = 1'b0;

    // Instance B counting up from 0 for six edges.
    x = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_val("up_seq_b", q_b, exp_up[i]);
      if (i == 2) check_val("up_wrap_b_pre", wrap_b, 0);
      if (i == 3) check_val("up_wrap_b_set", wrap_b, 1);
    end

    // Park B at the top, then clear coinciding with a wrap: set wins.
    load = 1'b1; en = 1'b0; d_a = 4'd9; d_b = 2'd3;
    cycle();
    load = 1'b0; en = 1'b1; x = 1'b1; clr_wrap = 1'b1;
    cycle();
    check_val("clr_vs_set_b", wrap_b, 1);
    en = 1'b0;
    cycle();
    check_val("clr_alone_b", wrap_b, 0);
    clr_wrap = 1'b0;

    // Enable low: count holds.
    for (int i = 0; i < 3; i++) begin
      x = 1'($urandom_range(0, 1));
      cycle();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) < 7);
      x        = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 9) == 0);
      clr_wrap = ($urandom_range(0, 9) == 0);
      d_a      = 4'($urandom_range(0, 15));
      d_b      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        async_reset_check();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
